// File: rtl/instr_mem_resp.sv
// Instruction memory with a fixed-latency read pipeline feeding a 4-entry in-order response FIFO.
// Supports flush and program loading. Misaligned or out-of-range fetches return a flagged NOP.
module instr_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_instr_o,
  output logic [31:0] resp_addr_o,
  output logic        resp_err_o,
  input  logic        ld_en_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          PIPE = (LATENCY > 1) ? int'(LATENCY) - 1 : 1;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] instr;
  } resp_t;

  typedef struct packed {
    logic  valid;
    resp_t data;
  } entry_t;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] fetch_word;
  logic [31:0] ld_word;
  logic        accept;
  logic        pop;
  logic        push;
  entry_t      in_e;
  entry_t      wr_e;
  entry_t      pipe_q [PIPE];
  resp_t       fifo_q [4];
  resp_t       head;
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  cnt_q, occ_q;

  assign fetch_word = (req_addr_i - BASE_ADDR) >> 2;
  assign ld_word    = (ld_addr_i - BASE_ADDR) >> 2;

  assign req_ready_o = (occ_q < 3'd4);
  assign accept      = req_valid_i && req_ready_o && !flush_i;
  assign pop         = resp_valid_o && resp_ready_i;
  assign push        = wr_e.valid && !flush_i;

  // The memory is sampled in the accept cycle, so a same-edge load is not yet visible.
  always_comb begin
    in_e            = '0;
    in_e.valid      = accept;
    in_e.data.addr  = req_addr_i;
    in_e.data.err   = (req_addr_i[1:0] != 2'b00) || (fetch_word >= DEPTH_WORDS);
    in_e.data.instr = in_e.data.err ? NOP : mem_q[fetch_word[AW-1:0]];
  end

  // NOTE: memory contents are deliberately not reset; only the load strobe is gated by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && ld_en_i && (ld_word < DEPTH_WORDS)) begin
      mem_q[ld_word[AW-1:0]] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      for (int k = 0; k < PIPE; k++) pipe_q[k].valid <= 1'b0;
    end else begin
      pipe_q[0] <= in_e;
      for (int k = 1; k < PIPE; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  // With one cycle of latency the accepted request goes straight into the FIFO.
  if (LATENCY == 1) begin : g_direct
    assign wr_e = in_e;
  end else begin : g_piped
    assign wr_e = pipe_q[PIPE-1];
  end

  // Occupancy covers pipeline and FIFO, so the FIFO itself can never overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + {1'b0, push};
      rd_ptr_q <= rd_ptr_q + {1'b0, pop};
      cnt_q    <= cnt_q + {2'b00, push} - {2'b00, pop};
      occ_q    <= occ_q + {2'b00, accept} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= wr_e.data;
  end

  assign head         = fifo_q[rd_ptr_q];
  assign resp_valid_o = (cnt_q != 3'd0);
  assign resp_instr_o = resp_valid_o ? head.instr : NOP;
  assign resp_addr_o  = resp_valid_o ? head.addr  : 32'h0;
  assign resp_err_o   = resp_valid_o && head.err;

endmodule
